// File: rtl/pc_redirect_unit_if.sv
// Bundle between the EX stage and the PC redirect unit.
// The master side drives the EX-stage request; the slave side is the PC owner.
interface pc_redirect_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            Stall;
  logic            Branch_taken;
  logic            Jump;
  logic            Jalr;
  logic [XLEN-1:0] Ex_PC;
  logic [XLEN-1:0] Imm;
  logic [XLEN-1:0] Rs1;
  logic [XLEN-1:0] PC;
  logic            Flush;
  logic            Misalign_exc;
  logic [XLEN-1:0] Bad_addr;

  modport master (
    output Stall,
    output Branch_taken,
    output Jump,
    output Jalr,
    output Ex_PC,
    output Imm,
    output Rs1,
    input  PC,
    input  Flush,
    input  Misalign_exc,
    input  Bad_addr
  );

  modport slave (
    input  Stall,
    input  Branch_taken,
    input  Jump,
    input  Jalr,
    input  Ex_PC,
    input  Imm,
    input  Rs1,
    output PC,
    output Flush,
    output Misalign_exc,
    output Bad_addr
  );

endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC register and redirect controller. Takes resolved branch/jump requests
// from EX, loads the new fetch address, flushes wrong-path IF/ID contents for a
// fixed number of cycles and raises a one-cycle trap on a misaligned target.
module pc_redirect_unit #(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC    = 'h0000_0100,
  parameter int unsigned    FLUSH_CYCLES = 2
) (
  input logic               CLK,
  input logic               rst_n,
  pc_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StTrap  = 2'd1,
    StFlush = 2'd2
  } state_e;

  // Counter value loaded on entry to the flush state. After a trap one flush
  // cycle has already been spent in the trap state itself.
  localparam logic [2:0] FlushInit      = 3'(FLUSH_CYCLES);
  localparam logic [2:0] FlushAfterTrap = 3'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_q, bad_d;

  logic            req;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic [XLEN-1:0] pc_inc;

  assign req        = bus.Branch_taken | bus.Jump | bus.Jalr;
  assign pc_inc     = pc_q + XLEN'(4);
  // Bit 0 is cleared for JALR and ignored for the others; only bit 1 traps.
  assign misaligned = target[1];

  // Redirect target selection, JALR has priority.
  always_comb begin
    target = bus.Ex_PC + bus.Imm;
    if (bus.Jalr) begin
      target = (bus.Rs1 + bus.Imm) & ~XLEN'(1);
    end
  end

  // Next-state, next-PC and trap address logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    unique case (state_q)
      StRun: begin
        if (req) begin
          // A request wins over a stall: the wrong path must not keep fetching.
          if (misaligned) begin
            state_d = StTrap;
            bad_d   = target;
            pc_d    = TRAP_VEC;
            cnt_d   = '0;
          end else begin
            state_d = StFlush;
            pc_d    = target;
            cnt_d   = FlushInit;
          end
        end else if (!bus.Stall) begin
          pc_d = pc_inc;
        end
      end
      StTrap: begin
        // Trap cycle ignores all inputs; PC stays at the trap vector.
        if (FLUSH_CYCLES > 1) begin
          state_d = StFlush;
          cnt_d   = FlushAfterTrap;
        end else begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StFlush: begin
        if (!bus.Stall) begin
          pc_d = pc_inc;
        end
        if (cnt_q <= 3'd1) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, PC and trap address registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      pc_q    <= RESET_VEC;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
    end
  end

  // Outputs decode registered state only, so there is no path from the request.
  assign bus.PC           = pc_q;
  assign bus.Bad_addr     = bad_q;
  assign bus.Flush        = (state_q != StRun);
  assign bus.Misalign_exc = (state_q == StTrap);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomized and directed bench for pc_redirect_unit against a cycle-count model.
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_VEC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
  localparam int          FLUSH_CYCLES = 2;

  logic CLK;
  logic rst_n;

  pc_redirect_unit_if #(.XLEN(32)) bus ();

  pc_redirect_unit #(
    .XLEN        (32),
    .RESET_VEC   (RESET_VEC),
    .TRAP_VEC    (TRAP_VEC),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fetch PC, flush cycles still owed, trap cycle pending.
  logic [31:0] m_pc;
  logic [31:0] m_bad;
  int          m_flush_left;
  bit          m_trap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc         = RESET_VEC;
    m_bad        = '0;
    m_flush_left = 0;
    m_trap       = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".pc"},    bus.PC,                  m_pc);
    check_eq({tag, ".flush"}, 32'(bus.Flush),          32'(m_flush_left > 0));
    check_eq({tag, ".exc"},   32'(bus.Misalign_exc),   32'(m_trap));
    check_eq({tag, ".bad"},   bus.Bad_addr,            m_bad);
  endtask

  // Apply one cycle of inputs, advance the model and the DUT, then compare.
  task automatic step(input string tag, input bit stall, input bit br, input bit jump,
                      input bit jalr, input logic [31:0] ex_pc, input logic [31:0] imm,
                      input logic [31:0] rs1);
    logic [31:0] tgt;
    bus.Stall        = stall;
    bus.Branch_taken = br;
    bus.Jump         = jump;
    bus.Jalr         = jalr;
    bus.Ex_PC        = ex_pc;
    bus.Imm          = imm;
    bus.Rs1          = rs1;
    if (m_flush_left > 0) begin
      // Requests during a flush belong to wrong-path instructions.
      if (m_trap) m_trap = 1'b0;
      else if (!stall) m_pc = m_pc + 32'd4;
      m_flush_left--;
    end else if (br || jump || jalr) begin
      tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (ex_pc + imm);
      if (tgt[1]) begin
        m_bad  = tgt;
        m_pc   = TRAP_VEC;
        m_trap = 1'b1;
      end else begin
        m_pc = tgt;
      end
      m_flush_left = FLUSH_CYCLES;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input bit stall);
    step(tag, stall, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    bus.Stall = 1'b0; bus.Branch_taken = 1'b0; bus.Jump = 1'b0; bus.Jalr = 1'b0;
    bus.Ex_PC = '0;   bus.Imm = '0;            bus.Rs1 = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_eq("reset.pc", bus.PC, RESET_VEC);
    check_eq("reset.flush", 32'(bus.Flush), 32'd0);
    check_eq("reset.exc", 32'(bus.Misalign_exc), 32'd0);
    check_eq("reset.bad", bus.Bad_addr, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch after reset.
    idle("seq0", 1'b0); check_eq("seq0.const", bus.PC, 32'h4);
    idle("seq1", 1'b0); check_eq("seq1.const", bus.PC, 32'h8);
    idle("seq2", 1'b0); check_eq("seq2.const", bus.PC, 32'hC);
    idle("seq3", 1'b0); check_eq("seq3.const", bus.PC, 32'h10);

    // Taken branch from PC 0x10.
    step("br", 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h20, 32'h0);
    check_eq("br.target", bus.PC, 32'h28);
    check_eq("br.flush1", 32'(bus.Flush), 32'd1);
    // A branch inside the flush window must be ignored.
    step("br_in_flush", 1'b0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h80, 32'h0);
    check_eq("br.pc2c", bus.PC, 32'h2C);
    check_eq("br.flush2", 32'(bus.Flush), 32'd1);
    idle("br_end", 1'b0);
    check_eq("br.pc30", bus.PC, 32'h30);
    check_eq("br.flush_off", 32'(bus.Flush), 32'd0);

    // JALR clears bit 0, aligned, no trap.
    step("jalr", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h1001);
    check_eq("jalr.const", bus.PC, 32'h1004);
    check_eq("jalr.noexc", 32'(bus.Misalign_exc), 32'd0);
    idle("jalr_f1", 1'b0);
    idle("jalr_f2", 1'b0);

    // Misaligned JAL target traps.
    step("jal_trap", 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h6, 32'h0);
    check_eq("trap.exc", 32'(bus.Misalign_exc), 32'd1);
    check_eq("trap.bad", bus.Bad_addr, 32'h46);
    check_eq("trap.pc", bus.PC, 32'h100);
    idle("trap_f", 1'b0);
    check_eq("trap.exc_off", 32'(bus.Misalign_exc), 32'd0);
    check_eq("trap.flush2", 32'(bus.Flush), 32'd1);
    idle("trap_end", 1'b0);
    check_eq("trap.flush_off", 32'(bus.Flush), 32'd0);

    // Stall holds PC; stall together with branch still redirects.
    idle("stall0", 1'b1);
    idle("stall1", 1'b1);
    step("stall_br", 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0);
    check_eq("stall_br.const", bus.PC, 32'h240);
    idle("stall_br_f1", 1'b1);
    idle("stall_br_f2", 1'b0);

    // Wrap at the top of the address space.
    step("wrap_jalr", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'hFFFF_FFF0);
    idle("wrap_f1", 1'b0);
    idle("wrap_f2", 1'b0);
    check_eq("wrap.top", bus.PC, 32'hFFFF_FFFC);
    idle("wrap", 1'b0);
    check_eq("wrap.zero", bus.PC, 32'h0);

    // Asynchronous reset in the middle of a flush.
    step("rst_br", 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h10, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_mid");
    #2;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int unsigned kind;
      logic [31:0] imm;
      logic [31:0] ex_pc;
      bit          stall;
      kind  = $urandom_range(0, 9);
      stall = ($urandom_range(0, 3) == 0);
      ex_pc = $urandom & 32'hFFFF_FFFC;
      imm   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) imm = imm | 32'h2;
      if ($urandom_range(0, 5) == 0) imm = imm | 32'h1;
      step("rand", stall, kind <= 1, kind == 2, kind == 3, ex_pc, imm, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
